// File: rtl/accel_job_ctrl.sv
// accel_job_ctrl
// Job controller for the BRAM A/B -> C accelerator. Host software programs
// job length and control through a small register port; the block launches
// the compute engine, counts busy cycles and raises an XDMA user interrupt
// until acknowledged.
//
// Ports:
//   user_clk, user_resetn      clock, asynchronous active-low reset
//   cfg_wr_en/rd_en/addr/wdata register port (byte address, bits [1:0] ignored)
//   cfg_rdata, cfg_rvalid      registered read data, one cycle after cfg_rd_en
//   eng_start, eng_len         one-cycle launch pulse and job length to engine
//   eng_done                   one-cycle completion pulse from engine
//   usr_irq_req, usr_irq_ack   interrupt handshake toward XDMA
//   leds                       {timeout_err, irq_pending, busy, heartbeat}
//
// Register map: 0x00 CTRL, 0x04 STATUS, 0x08 LEN, 0x0C CYCLES, 0x10 TIMEOUT.
// Build option: define ACCEL_JOB_CTRL_TIMEOUT_EN to enable the job watchdog
// (TIMEOUT register and TMO_ERR status bit); otherwise both read as 0.
module accel_job_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 32
) (
  input  logic             user_clk,
  input  logic             user_resetn,
  input  logic             cfg_wr_en,
  input  logic             cfg_rd_en,
  input  logic [4:0]       cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  output logic             cfg_rvalid,
  output logic             eng_start,
  output logic [LEN_W-1:0] eng_len,
  input  logic             eng_done,
  output logic             usr_irq_req,
  input  logic             usr_irq_ack,
  output logic [3:0]       leds
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_IRQ} state_t;

  localparam logic [2:0] A_CTRL    = 3'd0;
  localparam logic [2:0] A_STATUS  = 3'd1;
  localparam logic [2:0] A_LEN     = 3'd2;
  localparam logic [2:0] A_CYCLES  = 3'd3;
  localparam logic [2:0] A_TIMEOUT = 3'd4;

  state_t           state, state_next;
  logic [2:0]       reg_sel;
  logic             ctrl_wr, start_wr, soft_rst, status_wr;
  logic             launch, done_set, tmo_set, busy;
  logic             irq_en, done_flag, tmo_err;
  logic [LEN_W-1:0] len_reg;
  logic [CNT_W-1:0] cycles, cnt_inc;
  logic [23:0]      hb_cnt;
  logic             hb;
  logic [31:0]      rd_mux;
  logic             unused_cfg;

  assign reg_sel   = cfg_addr[4:2];
  assign ctrl_wr   = cfg_wr_en && (reg_sel == A_CTRL);
  assign start_wr  = ctrl_wr && cfg_wdata[0];
  assign soft_rst  = ctrl_wr && cfg_wdata[2];
  assign status_wr = cfg_wr_en && (reg_sel == A_STATUS);
  assign unused_cfg = ^{cfg_addr[1:0], cfg_wdata};

  // Saturating increment of the job cycle counter
  assign cnt_inc = (&cycles) ? cycles : cycles + CNT_W'(1);

`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] timeout_reg;
`endif

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) state <= S_IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    done_set    = 1'b0;
    tmo_set     = 1'b0;
    eng_start   = 1'b0;
    usr_irq_req = 1'b0;
    busy        = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_wr) begin
          if (len_reg == '0) begin
            done_set = 1'b1;
          end else begin
            launch     = 1'b1;
            state_next = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        eng_start  = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        if (eng_done) begin
          done_set   = 1'b1;
          state_next = irq_en ? S_IRQ : S_IDLE;
        end
`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
        else if (cnt_inc >= timeout_reg) begin
          tmo_set    = 1'b1;
          state_next = irq_en ? S_IRQ : S_IDLE;
        end
`endif
      end
      S_IRQ: begin
        usr_irq_req = 1'b1;
        if (usr_irq_ack) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Soft reset overrides every event of this cycle, including a START
    if (soft_rst) begin
      state_next = S_IDLE;
      launch     = 1'b0;
      done_set   = 1'b0;
      tmo_set    = 1'b0;
    end
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
      len_reg   <= '0;
      cycles    <= '0;
      eng_len   <= '0;
    end else begin
      if (ctrl_wr) irq_en <= cfg_wdata[1];
      if (cfg_wr_en && (reg_sel == A_LEN)) len_reg <= cfg_wdata[LEN_W-1:0];
      // A DONE set in the same cycle as its W1C wins
      if (soft_rst)                       done_flag <= 1'b0;
      else if (done_set)                  done_flag <= 1'b1;
      else if (status_wr && cfg_wdata[1]) done_flag <= 1'b0;
      if (launch) eng_len <= len_reg;
      if (soft_rst || state == S_LAUNCH) cycles <= '0;
      else if (state == S_RUN)           cycles <= cnt_inc;
    end
  end

`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      timeout_reg <= '1;
      tmo_err     <= 1'b0;
    end else begin
      if (cfg_wr_en && (reg_sel == A_TIMEOUT)) timeout_reg <= cfg_wdata[CNT_W-1:0];
      if (soft_rst)                       tmo_err <= 1'b0;
      else if (tmo_set)                   tmo_err <= 1'b1;
      else if (status_wr && cfg_wdata[2]) tmo_err <= 1'b0;
    end
  end
`else
  assign tmo_err = tmo_set;
`endif

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      A_CTRL:    rd_mux[1]   = irq_en;
      A_STATUS:  rd_mux[2:0] = {tmo_err, done_flag, busy};
      A_LEN:     rd_mux      = 32'(len_reg);
      A_CYCLES:  rd_mux      = 32'(cycles);
`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
      A_TIMEOUT: rd_mux      = 32'(timeout_reg);
`endif
      default:   rd_mux      = '0;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_resetn) begin
    if (!user_resetn) begin
      cfg_rdata  <= '0;
      cfg_rvalid <= 1'b0;
      hb_cnt     <= '0;
      hb         <= 1'b0;
    end else begin
      cfg_rdata  <= cfg_rd_en ? rd_mux : '0;
      cfg_rvalid <= cfg_rd_en;
      hb_cnt     <= hb_cnt + 24'(1);
      if (&hb_cnt) hb <= ~hb;
    end
  end

  assign leds = {tmo_err, usr_irq_req, busy, hb};

endmodule

// File: tb/tb_accel_job_ctrl.sv
// Self-checking bench for accel_job_ctrl: randomized jobs against a
// register-level reference model; register reads and engine launches are
// checked by independent monitors popping expectation queues.
module tb_accel_job_ctrl;

  localparam logic [4:0] R_CTRL = 5'h00, R_STATUS = 5'h04, R_LEN = 5'h08,
                         R_CYCLES = 5'h0C, R_TIMEOUT = 5'h10;
`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
  localparam logic [31:0] TMO_RST = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TMO_RST = 32'h0;
`endif

  logic        user_clk = 1'b0;
  logic        user_resetn = 1'b0;
  logic        cfg_wr_en = 1'b0, cfg_rd_en = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata;
  logic        cfg_rvalid;
  logic        eng_start;
  logic [15:0] eng_len;
  logic        eng_done = 1'b0;
  logic        usr_irq_req;
  logic        usr_irq_ack = 1'b0;
  logic [3:0]  leds;

  accel_job_ctrl #(.LEN_W(16), .CNT_W(32)) dut (
    .user_clk(user_clk), .user_resetn(user_resetn),
    .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_rvalid(cfg_rvalid),
    .eng_start(eng_start), .eng_len(eng_len), .eng_done(eng_done),
    .usr_irq_req(usr_irq_req), .usr_irq_ack(usr_irq_ack), .leds(leds)
  );

  initial forever #5 user_clk = ~user_clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [15:0] start_q[$];
  int          start_cyc = 0;
  bit          start_seen = 0;
  int          eng_delay = 0;   // 0 = engine never completes
  logic        m_irq_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void check1(string name, logic act, logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endfunction

  // Read monitor: every returned word is matched against the scoreboard
  initial forever begin
    @(negedge user_clk);
    if (cfg_rvalid === 1'b1) begin
      if (exp_q.size() == 0) check1("rvalid_unexpected", cfg_rvalid, 1'b0);
      else check(name_q.pop_front(), cfg_rdata, exp_q.pop_front());
    end else begin
      check("rdata_idle_zero", cfg_rdata, 32'h0);
    end
  end

  // Launch monitor: each pulse-cycle must match one expected launch
  initial forever begin
    @(negedge user_clk);
    if (eng_start === 1'b1) begin
      if (start_q.size() == 0) check1("eng_start_unexpected", eng_start, 1'b0);
      else check("eng_len", {16'b0, eng_len}, {16'b0, start_q.pop_front()});
      start_cyc  = cyc;
      start_seen = 1'b1;
    end
  end

  // Engine model: completes eng_delay cycles after the start pulse
  initial forever begin
    @(negedge user_clk);
    if (eng_start === 1'b1 && eng_delay > 0) begin
      repeat (eng_delay) @(negedge user_clk);
      eng_done = 1'b1;
      @(negedge user_clk);
      eng_done = 1'b0;
      check1("irq_after_done", usr_irq_req, m_irq_en);
      check1("led_busy_after_done", leds[1], m_irq_en);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // All driver tasks are entered and left on a negative clock edge
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge user_clk);
    cfg_wr_en = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    cfg_rd_en = 1'b1; cfg_addr = a;
    exp_q.push_back(exp); name_q.push_back(name);
    @(negedge user_clk);
    cfg_rd_en = 1'b0;
  endtask

  task automatic ack_irq();
    usr_irq_ack = 1'b1;
    @(negedge user_clk);
    usr_irq_ack = 1'b0;
    check1("irq_low_after_ack", usr_irq_req, 1'b0);
  endtask

  task automatic start_job(input logic [15:0] len, input logic ie, input int d);
    eng_delay = d;
    start_seen = 1'b0;
    if (len != 0) start_q.push_back(len);
    m_irq_en = ie;
    wr(R_CTRL, {30'b0, ie, 1'b1});
  endtask

  task automatic wait_start(output int c_l);
    for (int i = 0; i < 5 && !start_seen; i++) @(negedge user_clk);
    check1("start_seen", start_seen, 1'b1);
    c_l = start_cyc;
  endtask

  task automatic run_job(input logic [15:0] len, input logic ie, input int d,
                         input int ack_dly, input bit poke);
    int   c_l;
    logic held;
    wr(R_LEN, {16'b0, len});
    rd(R_LEN, {16'b0, len}, "len_rb");
    start_job(len, ie, d);
    if (len == 0) begin
      rd(R_STATUS, 32'h2, "status_len0");
      wr(R_STATUS, 32'h2);
      rd(R_STATUS, 32'h0, "status_len0_w1c");
      return;
    end
    wait_start(c_l);
    if (poke) begin
      wr(R_CTRL, {30'b0, ie, 1'b1});       // START while busy: ignored
      rd(R_CYCLES, 32'(cyc - c_l - 1), "cycles_counting");
    end
    while (cyc < c_l + d + 1) @(negedge user_clk);
    rd(R_STATUS, {30'b0, 1'b1, ie}, "status_after_done");
    rd(R_CYCLES, 32'(d), "cycles_job");
    if (ie) begin
      if (poke) wr(R_CTRL, 32'h3);
      held = 1'b1;
      repeat (ack_dly) begin
        if (usr_irq_req !== 1'b1) held = 1'b0;
        @(negedge user_clk);
      end
      check1("irq_held_until_ack", held & usr_irq_req, 1'b1);
      ack_irq();
    end
    rd(R_STATUS, 32'h2, "status_idle_done");
    wr(R_STATUS, 32'h2);
    rd(R_STATUS, 32'h0, "status_w1c");
  endtask

  initial begin
    int c_l, irq_cyc;
    #1;
    check1("rst_eng_start", eng_start, 1'b0);
    check1("rst_irq", usr_irq_req, 1'b0);
    check("rst_leds", {28'b0, leds}, 32'h0);
    check1("rst_rvalid", cfg_rvalid, 1'b0);
    @(negedge user_clk); @(negedge user_clk);
    user_resetn = 1'b1;
    @(negedge user_clk);
    rd(R_STATUS, 32'h0, "rst_status");
    rd(R_TIMEOUT, TMO_RST, "rst_timeout");
    rd(R_CTRL, 32'h0, "rst_ctrl");
    check("rst_leds_321", {29'b0, leds[3:1]}, 32'h0);

    // Unmapped addresses
    wr(5'h18, 32'hDEAD_BEEF);
    rd(5'h14, 32'h0, "unmapped_14");
    rd(5'h1C, 32'h0, "unmapped_1c");

    // Directed job, then zero-length, then random jobs
    run_job(16'd8, 1'b1, 20, 3, 1'b1);
    run_job(16'd0, 1'b0, 5, 0, 1'b0);
    for (int j = 0; j < 6; j++)
      run_job(16'($urandom_range(1, 400)), 1'($urandom_range(0, 1)),
              int'($urandom_range(3, 40)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)));

    // DONE set and W1C in the same cycle: set wins
    wr(R_LEN, 32'd3);
    start_job(16'd3, 1'b0, 10);
    wait_start(c_l);
    while (cyc < c_l + 10) @(negedge user_clk);
    wr(R_STATUS, 32'h2);
    rd(R_STATUS, 32'h2, "done_set_beats_w1c");
    wr(R_STATUS, 32'h2);
    rd(R_STATUS, 32'h0, "done_cleared");

    // Watchdog behaviour
    wr(R_LEN, 32'd5);
`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
    wr(R_TIMEOUT, 32'd50);
    rd(R_TIMEOUT, 32'd50, "timeout_rb");
    start_job(16'd5, 1'b1, 0);
    wait_start(c_l);
    irq_cyc = -1;
    for (int i = 0; i < 80 && irq_cyc < 0; i++) begin
      if (usr_irq_req === 1'b1) irq_cyc = cyc;
      else @(negedge user_clk);
    end
    check("timeout_irq_cycle", 32'(irq_cyc), 32'(c_l + 51));
    rd(R_STATUS, 32'h5, "status_timeout_irq");
    rd(R_CYCLES, 32'd50, "cycles_timeout");
    ack_irq();
    rd(R_STATUS, 32'h4, "status_timeout");
    wr(R_STATUS, 32'h4);
    rd(R_STATUS, 32'h0, "status_tmo_w1c");
`else
    start_job(16'd5, 1'b1, 0);
    wait_start(c_l);
    wr(R_TIMEOUT, 32'd50);
    rd(R_TIMEOUT, 32'h0, "timeout_disabled");
    repeat (1000) @(negedge user_clk);
    rd(R_STATUS, 32'h1, "still_busy");
    rd(R_CYCLES, 32'(cyc - c_l - 1), "cycles_no_timeout");
    wr(R_CTRL, 32'h6);
    rd(R_STATUS, 32'h0, "soft_rst_clears_busy");
`endif

    // SOFT_RST during RUN keeps LEN and IRQ_EN
    wr(R_LEN, 32'd77);
    start_job(16'd77, 1'b1, 0);
    wait_start(c_l);
    repeat (5) @(negedge user_clk);
    wr(R_CTRL, 32'h6);
    rd(R_STATUS, 32'h0, "softrst_status");
    rd(R_CYCLES, 32'h0, "softrst_cycles");
    rd(R_LEN, 32'd77, "softrst_len_kept");
    rd(R_CTRL, 32'h2, "softrst_irq_en_kept");
    check1("softrst_irq", usr_irq_req, 1'b0);

    // SOFT_RST together with START: no launch
    wr(R_CTRL, 32'h7);
    repeat (3) @(negedge user_clk);
    rd(R_STATUS, 32'h0, "softrst_start_status");

    // Hardware reset while in IRQ
    wr(R_LEN, 32'd9);
    start_job(16'd9, 1'b1, 5);
    wait_start(c_l);
    for (int i = 0; i < 20 && usr_irq_req !== 1'b1; i++) @(negedge user_clk);
    check1("irq_before_reset", usr_irq_req, 1'b1);
    repeat (2) @(negedge user_clk);
    user_resetn = 1'b0;
    m_irq_en = 1'b0;
    #1;
    check1("async_rst_irq", usr_irq_req, 1'b0);
    check("async_rst_leds", {29'b0, leds[3:1]}, 32'h0);
    @(negedge user_clk);
    user_resetn = 1'b1;
    @(negedge user_clk);
    rd(R_STATUS, 32'h0, "post_rst_status");
    rd(R_LEN, 32'h0, "post_rst_len");
    rd(R_CTRL, 32'h0, "post_rst_ctrl");
    rd(R_TIMEOUT, TMO_RST, "post_rst_timeout");

    repeat (3) @(negedge user_clk);
    check("read_queue_drained", 32'(exp_q.size()), 32'h0);
    check("start_queue_drained", 32'(start_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
